// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// and the load/store stage. Data wins by default; a starvation counter makes
// sure a waiting fetch eventually gets the port.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_resp_valid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_resp_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH/8-1:0] mem_wmask_q, mem_wmask_d;
  logic                    fetch_forced;

  // Arbitrate in IDLE, latch the winner's request, and release the port once
  // the memory answers; everything downstream is held constant while busy.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    fetch_forced = if_req && (starve_cnt_q == LIMIT);
    unique case (state_q)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wmask_d = d_wmask;
          if (if_req && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (if_req) begin
          state_d      = BUSY_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          mem_wmask_d  = '0;
          starve_cnt_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp_valid) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and downstream request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

  // Responses are routed to the current owner in the same cycle they arrive;
  // read data is simply fanned out to both requesters.
  assign if_resp_valid = (state_q == BUSY_I) && mem_resp_valid;
  assign d_resp_valid  = (state_q == BUSY_D) && mem_resp_valid;
  assign if_rdata      = mem_rdata;
  assign d_rdata       = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the memory port
// arbiter against a transaction-level model of its arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int MW    = DW / 8;
  localparam int LIMIT = 4;

  localparam int DIRECTED = 0;
  localparam int HOLD     = 1;
  localparam int RANDOM   = 2;

  localparam int OWN_NONE  = 0;
  localparam int OWN_FETCH = 1;
  localparam int OWN_DATA  = 2;

  localparam logic [AW-1:0] FADDR = 64'h0000_0000_1000_0000;
  localparam logic [AW-1:0] DADDR = 64'h0000_0000_2000_0000;

  logic          clk, rstn;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [MW-1:0] d_wmask;
  logic          if_resp_valid, d_resp_valid;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  // Free-running core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the port, the starvation count, and the
  // request currently presented downstream.
  int            mOwner;
  int            mStarve;
  logic          mReq, mWe;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata;
  logic [MW-1:0] mWmask;
  bit            mWdataKnown;

  // Bench-side memory and requester behaviour.
  int            mode;
  bit            memEnable, spurious, forceResp, randData;
  int            memWait, memLatency;
  logic [DW-1:0] nextRdata;
  bit            lastIfRv, lastDRv;

  // Observation helpers.
  bit   logOn;
  int   grantLog[$];
  logic prevReq;
  int   ifPulses, dPulses;

  task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive memory response and requester inputs for the coming cycle.
  task automatic applyStimulus();
    mem_resp_valid = 1'b0;
    if (randData) nextRdata = {$urandom, $urandom};
    mem_rdata = nextRdata;
    if (forceResp) begin
      mem_resp_valid = 1'b1;
    end else if (memEnable && mReq && memWait >= memLatency) begin
      mem_resp_valid = 1'b1;
    end else if (spurious && !mReq && $urandom_range(0, 5) == 0) begin
      mem_resp_valid = 1'b1;
    end
    case (mode)
      DIRECTED: begin
        if (lastIfRv) if_req = 1'b0;
        if (lastDRv)  d_req  = 1'b0;
      end
      RANDOM: begin
        if (!if_req || lastIfRv) begin
          if_req  = ($urandom_range(0, 2) == 0);
          if_addr = {$urandom, $urandom};
        end else if ($urandom_range(0, 31) == 0) begin
          if_req = 1'b0;
        end
        if (!d_req || lastDRv) begin
          d_req   = ($urandom_range(0, 1) == 0);
          d_we    = $urandom_range(0, 1) == 1;
          d_addr  = {$urandom, $urandom};
          d_wdata = {$urandom, $urandom};
          d_wmask = 8'($urandom);
        end else if ($urandom_range(0, 31) == 0) begin
          d_req = 1'b0;
        end
        rstn = ($urandom_range(0, 63) != 0);
      end
      default: ;
    endcase
  endtask

  // Compare every observable output against the model, mid-cycle.
  task automatic checkOutput();
    logic expIfRv, expDRv;
    #1;
    expIfRv = (mOwner == OWN_FETCH) && mem_resp_valid;
    expDRv  = (mOwner == OWN_DATA)  && mem_resp_valid;
    expectEq("mem_req",       64'(mem_req),       64'(mReq));
    expectEq("mem_we",        64'(mem_we),        64'(mWe));
    expectEq("mem_addr",      mem_addr,           mAddr);
    expectEq("mem_wmask",     64'(mem_wmask),     64'(mWmask));
    expectEq("if_resp_valid", 64'(if_resp_valid), 64'(expIfRv));
    expectEq("d_resp_valid",  64'(d_resp_valid),  64'(expDRv));
    if (mWdataKnown) expectEq("mem_wdata", mem_wdata, mWdata);
    if (expIfRv)     expectEq("if_rdata",  if_rdata,  mem_rdata);
    if (expDRv)      expectEq("d_rdata",   d_rdata,   mem_rdata);
    lastIfRv = expIfRv;
    lastDRv  = expDRv;
    if (if_resp_valid === 1'b1) ifPulses++;
    if (d_resp_valid === 1'b1)  dPulses++;
    if (logOn && mem_req === 1'b1 && prevReq !== 1'b1)
      grantLog.push_back((mem_addr === FADDR) ? OWN_FETCH : OWN_DATA);
    prevReq = mem_req;
  endtask

  // Apply the arbitration rules to the current inputs, then take the edge.
  task automatic advance();
    bit respNow, oldReq;
    respNow = mem_resp_valid;
    oldReq  = mReq;
    if (!rstn) begin
      mOwner = OWN_NONE; mStarve = 0; mReq = 0; mWe = 0;
      mAddr = '0; mWdata = '0; mWmask = '0; mWdataKnown = 1;
    end else if (mOwner == OWN_NONE) begin
      if (d_req && !(if_req && mStarve >= LIMIT)) begin
        mOwner = OWN_DATA; mReq = 1; mWe = d_we; mAddr = d_addr;
        mWdata = d_wdata; mWmask = d_wmask; mWdataKnown = 1;
        if (if_req) mStarve = (mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1;
      end else if (if_req) begin
        mOwner = OWN_FETCH; mReq = 1; mWe = 0; mAddr = if_addr;
        mWmask = '0; mWdataKnown = 0; mStarve = 0;
      end
    end else if (respNow) begin
      mOwner = OWN_NONE;
      mReq   = 0;
    end
    if (mReq && oldReq && !respNow) memWait++;
    else memWait = 0;
    if (mode == RANDOM && mReq && !oldReq) memLatency = $urandom_range(0, 3);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    applyStimulus();
    checkOutput();
    advance();
  endtask

  task automatic clearCounts();
    ifPulses = 0;
    dPulses  = 0;
  endtask

  // Directed scenarios first, then a long randomized run.
  initial begin
    int expPat[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    rstn = 1'b0; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_resp_valid = 0; mem_rdata = '0;
    mOwner = OWN_NONE; mStarve = 0; mReq = 0; mWe = 0;
    mAddr = '0; mWdata = '0; mWmask = '0; mWdataKnown = 1;
    mode = DIRECTED; memEnable = 1; spurious = 0; forceResp = 0;
    randData = 0; nextRdata = '0; memWait = 0; memLatency = 3;
    lastIfRv = 0; lastDRv = 0; logOn = 0; prevReq = 0;
    clearCounts();

    @(negedge clk);
    advance();
    step();
    rstn = 1'b1;

    // Single fetch, memory answers 3 cycles after mem_req.
    clearCounts();
    nextRdata = 64'h13; memLatency = 3;
    if_req = 1; if_addr = 64'h1000;
    repeat (8) step();
    expectEq("t1_if_pulses", 64'(ifPulses), 64'd1);
    expectEq("t1_d_pulses",  64'(dPulses),  64'd0);

    // Single store with a partial byte mask.
    clearCounts();
    memLatency = 2; nextRdata = 64'h55;
    d_req = 1; d_we = 1; d_addr = 64'h2008;
    d_wdata = 64'hDEAD_BEEF; d_wmask = 8'h0F;
    repeat (7) step();
    expectEq("t2_d_pulses",  64'(dPulses),  64'd1);
    expectEq("t2_if_pulses", 64'(ifPulses), 64'd0);

    // Simultaneous requests: data first, then fetch.
    clearCounts();
    memLatency = 1; logOn = 1; grantLog.delete();
    if_req = 1; if_addr = FADDR;
    d_req = 1; d_we = 0; d_addr = DADDR;
    repeat (12) step();
    expectEq("t3_grants", 64'(grantLog.size()), 64'd2);
    if (grantLog.size() >= 2) begin
      expectEq("t3_first",  64'(grantLog[0]), 64'(OWN_DATA));
      expectEq("t3_second", 64'(grantLog[1]), 64'(OWN_FETCH));
    end

    // Both requesters hold continuously: four data grants then one fetch.
    mode = HOLD; memLatency = 0; grantLog.delete();
    if_req = 1; if_addr = FADDR; d_req = 1; d_addr = DADDR;
    repeat (21) step();
    expectEq("t4_grants", 64'(grantLog.size()), 64'd10);
    for (int i = 0; i < 10 && i < grantLog.size(); i++)
      expectEq($sformatf("t4_grant%0d", i), 64'(grantLog[i]), 64'(expPat[i]));
    logOn = 0; mode = DIRECTED; if_req = 0; d_req = 0;
    repeat (4) step();

    // Reset while a store is in flight; the late response must be dropped.
    clearCounts();
    memEnable = 0;
    d_req = 1; d_we = 1; d_addr = 64'h3000; d_wdata = 64'h1234_5678_9ABC_DEF0; d_wmask = 8'hFF;
    repeat (2) step();
    rstn = 0; d_req = 0;
    step();
    rstn = 1; forceResp = 1;
    step();
    expectEq("t5_mem_req",   64'(mem_req),   64'd0);
    expectEq("t5_mem_addr",  mem_addr,       64'd0);
    expectEq("t5_mem_wdata", mem_wdata,      64'd0);
    expectEq("t5_mem_wmask", 64'(mem_wmask), 64'd0);
    expectEq("t5_d_pulses",  64'(dPulses),   64'd0);
    forceResp = 0; memEnable = 1;
    step();

    // Stray memory response while idle.
    clearCounts();
    forceResp = 1;
    repeat (3) step();
    forceResp = 0;
    step();
    expectEq("t6_pulses", 64'(ifPulses + dPulses), 64'd0);
    expectEq("t6_mem_req", 64'(mem_req), 64'd0);

    // Randomized traffic, latencies, abandons, stray responses and resets.
    mode = RANDOM; spurious = 1; randData = 1;
    repeat (3000) step();
    mode = DIRECTED; spurious = 0; rstn = 1; if_req = 0; d_req = 0; memLatency = 1;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
